tournament_predictor: RTL and testbench

Parametrised tournament (local / global-gshare / meta-chooser) conditional branch predictor for the fetch stage. It gives a same-cycle taken/not-taken prediction for the fetch IP and carries the component predictions down a configurable-depth pipe to execute. At execute it trains N-bit saturating counters and the branch histories. It adds the following over the previous generation:
- synchronous table-clearing reset with a ready handshake
- configurable counter width and pipeline depth
- fetch stall support
- a registered mispredict flag

---
 rtl/tournament_predictor.sv | 186 ++++++++++++++++++
 tb/tb_tournament_predictor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tournament_predictor.sv
// rtl/tournament_predictor.sv - tournament (local / gshare / meta) conditional branch predictor
//
// Purpose: same-cycle taken/not-taken prediction for the fetch IP, component
// predictions carried down a PIPE_DEPTH pipe to execute, and training of
// saturating counters plus local/global histories when branches resolve.
//
// Ports:
//   CLOCK_50      system clock, all state on rising edge
//   reset         synchronous, active-high; restarts the table-clearing sweep
//   IP_f          fetch instruction pointer
//   stall         holds the prediction pipe
//   wouldExecute  an instruction resolves in execute this cycle
//   expectedIP    IP of the resolving instruction
//   wasJump       resolving instruction is a conditional branch
//   didJump       resolved direction (1 = taken)
//   prediction    combinational prediction for IP_f (0 while not ready)
//   ready         tables initialised
//   mispredict    one-cycle pulse after a mispredicted branch is trained

module tournament_predictor #(
  parameter int IP_WIDTH        = 16,
  parameter int LOCAL_HIST_LEN  = 6,
  parameter int LOCAL_HIST_IDX  = 10,
  parameter int LOCAL_BIT_IDX   = 5,
  parameter int GLOBAL_HIST_LEN = 12,
  parameter int GLOBAL_BIT_IDX  = 12,
  parameter int META_BIT_IDX    = 10,
  parameter int CTR_WIDTH       = 2,
  parameter int PIPE_DEPTH      = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [IP_WIDTH-1:0] IP_f,
  input  logic                stall,
  input  logic                wouldExecute,
  input  logic [IP_WIDTH-1:0] expectedIP,
  input  logic                wasJump,
  input  logic                didJump,
  output logic                prediction,
  output logic                ready,
  output logic                mispredict
);

  localparam int LCI   = LOCAL_BIT_IDX + LOCAL_HIST_LEN;
  localparam int M_A   = (LCI > GLOBAL_BIT_IDX) ? LCI : GLOBAL_BIT_IDX;
  localparam int M_B   = (META_BIT_IDX > LOCAL_HIST_IDX) ? META_BIT_IDX : LOCAL_HIST_IDX;
  localparam int SWP_W = (M_A > M_B) ? M_A : M_B;

  localparam logic [CTR_WIDTH-1:0] CTR_INIT = {1'b0, {(CTR_WIDTH-1){1'b1}}};
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [SWP_W-1:0]           sweep_q;
  logic [GLOBAL_HIST_LEN-1:0] ghr_q;
  logic [GLOBAL_BIT_IDX-1:0]  ghr_ext;

  logic [CTR_WIDTH-1:0]      local_ctr  [0:(1<<LCI)-1];
  logic [CTR_WIDTH-1:0]      global_ctr [0:(1<<GLOBAL_BIT_IDX)-1];
  logic [CTR_WIDTH-1:0]      meta_ctr   [0:(1<<META_BIT_IDX)-1];
  logic [LOCAL_HIST_LEN-1:0] local_hist [0:(1<<LOCAL_HIST_IDX)-1];

  // Pipe entry layout: {PL, PG, prediction}
  logic [2:0] pipe_q [PIPE_DEPTH];

  logic [IP_WIDTH-1:0] ja_q;
  logic                upd_q, dj_q, pl_r, pg_r, p_r;

  function automatic logic [CTR_WIDTH-1:0] ctr_step(input logic [CTR_WIDTH-1:0] c,
                                                    input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_WIDTH'(1);
    else    return (c == '0)      ? c : c - CTR_WIDTH'(1);
  endfunction

  // FSM: sweep every table once, then run
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && (&sweep_q)) state_d = ST_RUN;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)                  sweep_q <= '0;
    else if (state_q == ST_INIT) sweep_q <= sweep_q + SWP_W'(1);
  end

  assign ready   = (state_q == ST_RUN);
  assign ghr_ext = GLOBAL_BIT_IDX'(ghr_q);

  // Fetch lookup
  logic [LOCAL_HIST_LEN-1:0] f_lbh;
  logic [LCI-1:0]            f_lidx;
  logic [GLOBAL_BIT_IDX-1:0] f_gidx;
  logic                      f_pl, f_pg, f_pm, f_pred;

  assign f_lbh  = local_hist[IP_f[LOCAL_HIST_IDX-1:0]];
  assign f_lidx = {IP_f[LOCAL_BIT_IDX-1:0], f_lbh};
  assign f_gidx = IP_f[GLOBAL_BIT_IDX-1:0] ^ ghr_ext;
  assign f_pl   = local_ctr[f_lidx][CTR_WIDTH-1];
  assign f_pg   = global_ctr[f_gidx][CTR_WIDTH-1];
  assign f_pm   = meta_ctr[IP_f[META_BIT_IDX-1:0]][CTR_WIDTH-1];
  assign f_pred = f_pm ? f_pg : f_pl;
  assign prediction = ready & f_pred;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) pipe_q[i] <= '0;
    end else if (ready && !stall) begin
      pipe_q[0] <= {f_pl, f_pg, f_pred};
      for (int i = 1; i < PIPE_DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Capture stage: pair the resolving instruction with the pipe tail
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ja_q  <= '0;
      upd_q <= 1'b0;
      dj_q  <= 1'b0;
      pl_r  <= 1'b0;
      pg_r  <= 1'b0;
      p_r   <= 1'b0;
    end else if (ready && wouldExecute) begin
      ja_q  <= expectedIP;
      upd_q <= wasJump;
      dj_q  <= didJump;
      {pl_r, pg_r, p_r} <= pipe_q[PIPE_DEPTH-1];
    end else begin
      upd_q <= 1'b0;
    end
  end

  // Update stage indices, all taken from pre-update histories
  logic [LOCAL_HIST_LEN-1:0] u_lbh;
  logic [LCI-1:0]            u_lidx;
  logic [GLOBAL_BIT_IDX-1:0] u_gidx;
  logic [META_BIT_IDX-1:0]   u_midx;
  logic [LOCAL_HIST_IDX-1:0] u_lha;

  assign u_lha  = ja_q[LOCAL_HIST_IDX-1:0];
  assign u_lbh  = local_hist[u_lha];
  assign u_lidx = {ja_q[LOCAL_BIT_IDX-1:0], u_lbh};
  assign u_gidx = ja_q[GLOBAL_BIT_IDX-1:0] ^ ghr_ext;
  assign u_midx = ja_q[META_BIT_IDX-1:0];

  // Tables have no reset of their own; the INIT sweep clears them. Writes
  // are suppressed while reset is high so an in-flight update is dropped.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      if (state_q == ST_INIT) begin
        local_ctr[sweep_q[LCI-1:0]]             <= CTR_INIT;
        global_ctr[sweep_q[GLOBAL_BIT_IDX-1:0]] <= CTR_INIT;
        meta_ctr[sweep_q[META_BIT_IDX-1:0]]     <= CTR_INIT;
        local_hist[sweep_q[LOCAL_HIST_IDX-1:0]] <= '0;
      end else if (upd_q) begin
        local_ctr[u_lidx]  <= ctr_step(local_ctr[u_lidx], dj_q);
        global_ctr[u_gidx] <= ctr_step(global_ctr[u_gidx], dj_q);
        // Meta only learns when the components disagree
        if (pl_r != pg_r) meta_ctr[u_midx] <= ctr_step(meta_ctr[u_midx], pg_r == dj_q);
        local_hist[u_lha]  <= {u_lbh[LOCAL_HIST_LEN-2:0], dj_q};
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ghr_q      <= '0;
      mispredict <= 1'b0;
    end else begin
      mispredict <= 1'b0;
      if (upd_q) begin
        ghr_q      <= {ghr_q[GLOBAL_HIST_LEN-2:0], dj_q};
        mispredict <= (p_r != dj_q);
      end
    end
  end

  logic unused_ip_bits;
  assign unused_ip_bits = ^{IP_f, ja_q};

endmodule

// File: tb/tb_tournament_predictor.sv
// tb/tb_tournament_predictor.sv - directed self-checking bench for tournament_predictor

module tb_tournament_predictor;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [15:0] IP_f;
  logic        stall;
  logic        wouldExecute;
  logic [15:0] expectedIP;
  logic        wasJump;
  logic        didJump;
  logic        prediction;
  logic        ready;
  logic        mispredict;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  tournament_predictor dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .IP_f        (IP_f),
    .stall       (stall),
    .wouldExecute(wouldExecute),
    .expectedIP  (expectedIP),
    .wasJump     (wasJump),
    .didJump     (didJump),
    .prediction  (prediction),
    .ready       (ready),
    .mispredict  (mispredict)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n   = 0;
    int bad = 0;
    do begin
      if (prediction !== 1'b0 || mispredict !== 1'b0) bad++;
      tick();
      n++;
    end while (!ready && n < 6000);
    check_eq({tag, "_cycles"}, n, exp_cycles);
    check_eq({tag, "_quiet"}, bad, 0);
  endtask

  task automatic predict(input logic [15:0] ip, input int exp, input string tag);
    IP_f = ip;
    #1;
    check_eq(tag, int'(prediction), exp);
  endtask

  // Fetch ip for two cycles so the pipe tail holds its prediction, then resolve it
  task automatic resolve(input logic [15:0] ip, input logic dj, input int exp_misp,
                         input string tag);
    IP_f  = ip;
    stall = 1'b0;
    tick();
    tick();
    wouldExecute = 1'b1;
    expectedIP   = ip;
    wasJump      = 1'b1;
    didJump      = dj;
    tick();
    wouldExecute = 1'b0;
    wasJump      = 1'b0;
    tick();
    check_eq(tag, int'(mispredict), exp_misp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; IP_f = 16'h0040; stall = 1'b0; wouldExecute = 1'b0;
    expectedIP = '0; wasJump = 1'b0; didJump = 1'b0;
    tick(); tick(); tick();
    check_eq("rst_ready", int'(ready), 0);
    check_eq("rst_misp", int'(mispredict), 0);
    check_eq("rst_pred", int'(prediction), 0);
    reset = 1'b0;
    wait_ready("init1", 4096);

    // Fresh tables: every counter weakly not-taken / weakly local
    predict(16'h0040, 0, "pred_init");
    resolve(16'h0040, 1'b1, 1, "misp_first_taken");       // L[0]=2, GHR=1
    tick();
    check_eq("misp_pulse_width", int'(mispredict), 0);
    predict(16'h0060, 1, "pred_local_trained");           // shares L[0]
    resolve(16'h0060, 1'b1, 0, "misp_correct");           // L[0]=3, M[060]=0, GHR=3
    resolve(16'h0020, 1'b0, 1, "misp_not_taken");         // L[0]=2, M[020]=2, GHR=6
    predict(16'h0020, 0, "pred_meta_selects_global");     // PG=0 chosen over PL=1

    // Local counter saturation via fresh IPs that all hit L[0]
    resolve(16'h0100, 1'b1, 0, "sat_up1");                // 2->3
    resolve(16'h0120, 1'b1, 0, "sat_up2");                // 3->3
    resolve(16'h0140, 1'b0, 1, "sat_down_from_max");      // 3->2
    predict(16'h0160, 1, "pred_after_sat_hi");
    resolve(16'h0160, 1'b0, 1, "sat_down2");              // 2->1
    resolve(16'h0180, 1'b0, 0, "sat_down3");              // 1->0
    resolve(16'h01A0, 1'b0, 0, "sat_down4");              // 0->0
    resolve(16'h01C0, 1'b1, 1, "sat_up_from_min");        // 0->1
    predict(16'h01E0, 0, "pred_after_sat_lo");

    // Back-to-back resolves, both fetched with L[0]=1 (predicted not-taken)
    IP_f = 16'h0200; tick();
    IP_f = 16'h0220; tick();
    wouldExecute = 1'b1; wasJump = 1'b1; expectedIP = 16'h0200; didJump = 1'b1; tick();
    expectedIP = 16'h0220; didJump = 1'b1; tick();
    wouldExecute = 1'b0; wasJump = 1'b0;
    check_eq("b2b_first_misp", int'(mispredict), 1);
    tick();
    check_eq("b2b_second_misp", int'(mispredict), 1);
    tick();
    check_eq("b2b_misp_clear", int'(mispredict), 0);
    predict(16'h0240, 1, "pred_after_b2b");               // L[0]=3

    // Stall: tail holds prediction 1 (0x0260), next stage holds 0 (0x0261)
    IP_f = 16'h0260; tick();
    IP_f = 16'h0261; tick();
    stall = 1'b1; IP_f = 16'h0262;
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b0;
    wouldExecute = 1'b1; wasJump = 1'b1; expectedIP = 16'h0260; didJump = 1'b0; tick();
    expectedIP = 16'h0261; didJump = 1'b0; tick();
    wouldExecute = 1'b0; wasJump = 1'b0;
    check_eq("stall_tail_held", int'(mispredict), 1);
    tick();
    check_eq("stall_next_pairs", int'(mispredict), 0);

    // Reset mid-run, then reset again part-way through the sweep
    reset = 1'b1; tick(); tick();
    check_eq("rst2_ready", int'(ready), 0);
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    check_eq("init_partial_ready", int'(ready), 0);
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
    wait_ready("init2", 4096);
    predict(16'h0060, 0, "pred_cleared_after_reinit");    // L[0] back to init
    predict(16'h0240, 0, "pred_cleared_after_reinit2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
